hack_data_mem: RTL and testbench
================================

// Module: hack_data_mem
// PURPOSE
//  Data-side responder for the Hack CPU bus. Decodes data_addr/out_m/write_m
//  into RAM, screen buffer and read-only I/O registers, and returns read data on in_m.
//  in_m is registered with 1-cycle latency. This fits the CPU's 2-phase stall/execute
//  cadence: the address is stable in the stall cycle and in_m is valid in the execute cycle.
//  Also provides a second read-only screen port for the video scanout block.
// PARAMETERS
//  RAM_WORDS    16384  general RAM depth, mapped at 0x0000..RAM_WORDS-1 (<=16384)
//  SCREEN_BASE  16384  first screen word address (0x4000)
//  SCREEN_WORDS 8192   screen buffer depth (0x4000..0x5FFF)
//  KBD_ADDR     24576  keyboard register address (0x6000)
//  SW_ADDR      24577  switch register address (0x6001)
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  resetN     in   1   synchronous active-low reset
//  data_addr  in   15  CPU data address
//  out_m      in   16  CPU write data
//  write_m    in   1   CPU write strobe, one cycle per store
//  in_m       out  16  read data for data_addr of the previous cycle
//  kbd_code   in   16  key code from keyboard front-end
//  kbd_strobe in   1   1-cycle pulse: latch kbd_code as the current key
//  kbd_release in  1   1-cycle pulse: key released, current key <= 0
//  SW         in   4   board switches, readable at SW_ADDR
//  vid_addr   in   13  screen word index for scanout (0..SCREEN_WORDS-1)
//  vid_data   out  16  screen word at vid_addr of the previous cycle
// BEHAVIOUR
//  - Reset (resetN=0 at edge): in_m<=0, vid_data<=0, kbd_reg<=0, sw_reg<=0, write_m ignored.
//    RAM and screen contents are NOT cleared. Reset mid-store drops the store.
//  - Decode is on data_addr each cycle:
//    RAM    = addr < RAM_WORDS
//    SCR    = SCREEN_BASE <= addr < SCREEN_BASE+SCREEN_WORDS
//    KBD    = addr == KBD_ADDR
//    SWR    = addr == SW_ADDR
//    else   = unmapped
//  - Write: with write_m=1, the word at addr in RAM or SCR is written at the edge.
//    Writes to KBD, SWR or unmapped addresses are ignored (no side effects).
//  - Read: in_m <= mem[addr] at every edge, independent of write_m.
//    Write-first: if write_m=1 in the same cycle, in_m <= out_m for RAM/SCR.
//  - I/O reads: KBD reads kbd_reg. SWR reads {12'b0, sw_reg}. Unmapped reads 0.
//  - kbd_reg updates:
//    kbd_strobe=1             -> kbd_reg <= kbd_code
//    kbd_release=1 (alone)    -> kbd_reg <= 0
//    both in the same cycle   -> strobe wins
//    neither                  -> hold
//  - A KBD read returns kbd_reg as it was before that edge's update.
//  - sw_reg <= SW every cycle (2-flop synchroniser; a read sees SW from >=2 cycles earlier).
//  - Video port: vid_data <= screen[vid_addr] every cycle, 1-cycle latency.
//    CPU write and video read of the same word in one cycle: vid_data gets the OLD
//    word (read-before-write); the new word is visible from the next read.
//  - Address width: only data_addr[14:0] exists. No wrap-around; out-of-range reads
//    are defined as 0.
// TESTING
//  1 Reset: hold resetN=0 with write_m=1, addr=5, out_m=0x1234 for 3 cycles.
//    -> in_m=0, vid_data=0; after release, reading addr 5 does not return 0x1234.
//  2 RAM: write 0xBEEF to addr 100, then read addr 100.
//    -> in_m=0xBEEF one cycle after the address is presented.
//    -> same-cycle write/read of addr 100 with 0x0F0F -> in_m=0x0F0F next cycle.
//  3 Screen: write 0xAAAA to 0x4005, then vid_addr=5.
//    -> vid_data=0xAAAA next cycle.
//    -> write 0x5555 to 0x4005 while vid_addr=5 -> vid_data=0xAAAA, then 0x5555.
//  4 Keyboard: strobe kbd_code=0x0041, then read 0x6000.
//    -> 0x0041; release -> 0x0000.
//    -> strobe 0x0042 and release in the same cycle -> 0x0042.
//    -> write 0x7777 to 0x6000 -> read still 0x0042.
//  5 Switches/unmapped: SW=4'b1010 held 3 cycles, read 0x6001 -> 0x000A.
//    -> write 0xFFFF to 0x7000, read 0x7000 -> 0x0000.
//  6 CPU cadence: alternate stall/execute cycles, addr held 2 cycles, write_m only in
//    execute cycles -> every execute-cycle in_m equals the scoreboard model.

Source files
------------

// File: rtl/hack_data_mem_if.sv
// Hack CPU data-side bus: address, write data and strobe from the CPU, read data back.
// Latency: in_m is returned one cycle after data_addr is presented.
// Backpressure: none; the responder accepts every cycle and never stalls the CPU.
interface hack_data_mem_if;
    logic [14:0] data_addr;
    logic [15:0] out_m;
    logic        write_m;
    logic [15:0] in_m;

    modport master (
        output data_addr,
        output out_m,
        output write_m,
        input  in_m
    );

    modport slave (
        input  data_addr,
        input  out_m,
        input  write_m,
        output in_m
    );
endinterface

// File: rtl/hack_data_mem.sv
// Hack CPU data responder: RAM, screen buffer, keyboard/switch registers, video read port.
// Latency: in_m and vid_data are registered, 1 cycle after the address is presented.
// Backpressure: none; every cycle is accepted, stores take effect at the clock edge.
//
// Ports:
//   clk, resetN         clock and synchronous active-low reset
//   bus (slave)         data_addr/out_m/write_m in, in_m out (write-first on RAM/screen)
//   kbd_code/_strobe    latch a new key code; kbd_release clears it (strobe wins)
//   SW                  board switches, synchronised and readable at SW_ADDR
//   vid_addr/vid_data   scanout read port into the screen buffer (read-before-write)
module hack_data_mem #(
    parameter int RAM_WORDS    = 16384,
    parameter int SCREEN_BASE  = 16384,
    parameter int SCREEN_WORDS = 8192,
    parameter int KBD_ADDR     = 24576,
    parameter int SW_ADDR      = 24577
) (
    input  logic                            clk,
    input  logic                            resetN,
    hack_data_mem_if.slave                  bus,
    input  logic [15:0]                     kbd_code,
    input  logic                            kbd_strobe,
    input  logic                            kbd_release,
    input  logic [3:0]                      SW,
    input  logic [$clog2(SCREEN_WORDS)-1:0] vid_addr,
    output logic [15:0]                     vid_data
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int SCR_AW = $clog2(SCREEN_WORDS);

    // Decode bounds held at 16 bits so SCREEN_BASE+SCREEN_WORDS (0x6000) fits.
    localparam logic [15:0] RAM_END = 16'(RAM_WORDS);
    localparam logic [15:0] SCR_LO  = 16'(SCREEN_BASE);
    localparam logic [15:0] SCR_HI  = 16'(SCREEN_BASE + SCREEN_WORDS);
    localparam logic [15:0] KBD_A   = 16'(KBD_ADDR);
    localparam logic [15:0] SW_A    = 16'(SW_ADDR);

    logic [15:0] ram    [RAM_WORDS];
    logic [15:0] screen [SCREEN_WORDS];

    logic [15:0]       kbd_reg;
    logic [3:0]        sw_meta;
    logic [3:0]        sw_reg;

    logic [15:0]       addr16;
    logic              is_ram;
    logic              is_scr;
    logic              is_kbd;
    logic              is_sw;
    logic [RAM_AW-1:0] ram_idx;
    logic [SCR_AW-1:0] scr_idx;
    logic [15:0]       rd_dat;

    assign addr16  = {1'b0, bus.data_addr};
    assign is_ram  = addr16 < RAM_END;
    assign is_scr  = (addr16 >= SCR_LO) && (addr16 < SCR_HI);
    assign is_kbd  = addr16 == KBD_A;
    assign is_sw   = addr16 == SW_A;
    assign ram_idx = RAM_AW'(bus.data_addr);
    assign scr_idx = SCR_AW'(addr16 - SCR_LO);

    // CPU read mux. A same-cycle store forwards out_m so the CPU sees its own write;
    // the I/O registers are never forwarded since stores to them are discarded.
    always_comb begin
        rd_dat = '0;
        if (is_ram) begin
            rd_dat = bus.write_m ? bus.out_m : ram[ram_idx];
        end else if (is_scr) begin
            rd_dat = bus.write_m ? bus.out_m : screen[scr_idx];
        end else if (is_kbd) begin
            rd_dat = kbd_reg;
        end else if (is_sw) begin
            rd_dat = {12'b0, sw_reg};
        end
    end

    // Storage arrays carry no reset; a store presented during reset is dropped.
    always_ff @(posedge clk) begin
        if (resetN && bus.write_m) begin
            if (is_ram) begin
                ram[ram_idx] <= bus.out_m;
            end
            if (is_scr) begin
                screen[scr_idx] <= bus.out_m;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            bus.in_m <= '0;
            vid_data <= '0;
            kbd_reg  <= '0;
            sw_meta  <= '0;
            sw_reg   <= '0;
        end else begin
            bus.in_m <= rd_dat;
            // Scanout sees the word as it was before this edge's CPU store.
            vid_data <= screen[vid_addr];
            sw_meta  <= SW;
            sw_reg   <= sw_meta;
            if (kbd_strobe) begin
                kbd_reg <= kbd_code;
            end else if (kbd_release) begin
                kbd_reg <= '0;
            end
        end
    end

endmodule

// File: tb/tb_hack_data_mem.sv
module tb_hack_data_mem;
    logic        clk = 1'b0;
    logic        resetN;
    logic [15:0] kbd_code;
    logic        kbd_strobe;
    logic        kbd_release;
    logic [3:0]  SW;
    logic [12:0] vid_addr;
    logic [15:0] vid_data;

    always #5 clk = ~clk;

    hack_data_mem_if bus ();

    hack_data_mem dut (
        .clk        (clk),
        .resetN     (resetN),
        .bus        (bus),
        .kbd_code   (kbd_code),
        .kbd_strobe (kbd_strobe),
        .kbd_release(kbd_release),
        .SW         (SW),
        .vid_addr   (vid_addr),
        .vid_data   (vid_data)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // One address-keyed map holds every stored RAM/screen word; a word never
    // stored since power-up is unknown and not compared.
    logic [15:0] mdl_mem [int];
    logic [15:0] mdl_kbd;
    logic [3:0]  sw_hist [$];
    logic [15:0] exp_in   = '0;
    logic [15:0] exp_vid  = '0;
    bit          exp_in_ok  = 1'b0;
    bit          exp_vid_ok = 1'b0;

    always @(posedge clk) begin : model
        int a;
        int va;
        a  = int'(bus.data_addr);
        va = 16384 + int'(vid_addr);
        if (!resetN) begin
            exp_in     = 16'h0;
            exp_in_ok  = 1'b1;
            exp_vid    = 16'h0;
            exp_vid_ok = 1'b1;
            mdl_kbd    = 16'h0;
            sw_hist.delete();
        end else begin
            exp_vid_ok = mdl_mem.exists(va);
            if (exp_vid_ok) exp_vid = mdl_mem[va];
            if (a < 24576) begin
                if (bus.write_m) begin
                    exp_in    = bus.out_m;
                    exp_in_ok = 1'b1;
                    mdl_mem[a] = bus.out_m;
                end else begin
                    exp_in_ok = mdl_mem.exists(a);
                    if (exp_in_ok) exp_in = mdl_mem[a];
                end
            end else if (a == 24576) begin
                exp_in    = mdl_kbd;
                exp_in_ok = 1'b1;
            end else if (a == 24577) begin
                // The read reflects the switches sampled two edges ago.
                exp_in    = (sw_hist.size() >= 2) ? {12'b0, sw_hist[sw_hist.size()-2]} : 16'h0;
                exp_in_ok = 1'b1;
            end else begin
                exp_in    = 16'h0;
                exp_in_ok = 1'b1;
            end
            if (kbd_strobe) mdl_kbd = kbd_code;
            else if (kbd_release) mdl_kbd = 16'h0;
            sw_hist.push_back(SW);
            if (sw_hist.size() > 4) void'(sw_hist.pop_front());
        end
    end

    always @(negedge clk) begin
        if (exp_in_ok)  check("model_in_m", bus.in_m, exp_in);
        if (exp_vid_ok) check("model_vid_data", vid_data, exp_vid);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu(input logic [14:0] a, input logic w, input logic [15:0] d);
        bus.data_addr = a;
        bus.write_m   = w;
        bus.out_m     = d;
    endtask

    logic [14:0] pool [8];

    initial begin
        pool[0] = 15'd100;   pool[1] = 15'h3FFF; pool[2] = 15'h4005; pool[3] = 15'h5FFF;
        pool[4] = 15'h6000;  pool[5] = 15'h6001; pool[6] = 15'h7000; pool[7] = 15'd200;

        kbd_code = 16'h0; kbd_strobe = 1'b0; kbd_release = 1'b0;
        SW = 4'h0; vid_addr = 13'd0;

        // 1: reset with a store pending
        resetN = 1'b0;
        cpu(15'd5, 1'b1, 16'h1234);
        repeat (3) step();
        check("reset_in_m", bus.in_m, 16'h0);
        check("reset_vid_data", vid_data, 16'h0);
        resetN = 1'b1;
        cpu(15'd5, 1'b0, 16'h0);
        step();
        checks++;
        if (bus.in_m === 16'h1234) begin
            errors++;
            $display("FAIL reset_store_dropped: got 0x%04h, required anything but 0x1234", bus.in_m);
        end

        // 2: RAM write then read, and same-cycle write/read
        cpu(15'd100, 1'b1, 16'hBEEF); step();
        check("ram_write_fwd", bus.in_m, 16'hBEEF);
        cpu(15'd100, 1'b0, 16'h0);    step();
        check("ram_read", bus.in_m, 16'hBEEF);
        cpu(15'd100, 1'b1, 16'h0F0F); step();
        check("ram_same_cycle", bus.in_m, 16'h0F0F);
        cpu(15'd100, 1'b0, 16'h0);    step();
        check("ram_reread", bus.in_m, 16'h0F0F);
        cpu(15'h3FFF, 1'b1, 16'h1111); step();
        cpu(15'h3FFF, 1'b0, 16'h0);    step();
        check("ram_last_word", bus.in_m, 16'h1111);

        // 3: screen and video port
        cpu(15'h4005, 1'b1, 16'hAAAA); step();
        cpu(15'h4005, 1'b0, 16'h0); vid_addr = 13'd5; step();
        check("vid_read", vid_data, 16'hAAAA);
        check("scr_cpu_read", bus.in_m, 16'hAAAA);
        cpu(15'h4005, 1'b1, 16'h5555); step();
        check("vid_read_before_write", vid_data, 16'hAAAA);
        cpu(15'h4005, 1'b0, 16'h0); step();
        check("vid_new_word", vid_data, 16'h5555);
        cpu(15'h5FFF, 1'b1, 16'h2222); vid_addr = 13'h1FFF; step();
        cpu(15'h5FFF, 1'b0, 16'h0); step();
        check("scr_last_word_vid", vid_data, 16'h2222);
        check("scr_last_word_cpu", bus.in_m, 16'h2222);

        // 4: keyboard register
        kbd_code = 16'h0041; kbd_strobe = 1'b1; step();
        kbd_strobe = 1'b0; cpu(15'h6000, 1'b0, 16'h0); step();
        check("kbd_strobe", bus.in_m, 16'h0041);
        kbd_release = 1'b1; step();
        check("kbd_read_before_release", bus.in_m, 16'h0041);
        kbd_release = 1'b0; step();
        check("kbd_release", bus.in_m, 16'h0000);
        kbd_code = 16'h0042; kbd_strobe = 1'b1; kbd_release = 1'b1; step();
        kbd_strobe = 1'b0; kbd_release = 1'b0; step();
        check("kbd_strobe_wins", bus.in_m, 16'h0042);
        cpu(15'h6000, 1'b1, 16'h7777); step();
        check("kbd_write_no_fwd", bus.in_m, 16'h0042);
        cpu(15'h6000, 1'b0, 16'h0); step();
        check("kbd_write_ignored", bus.in_m, 16'h0042);

        // 5: switches and unmapped space
        SW = 4'b1010; cpu(15'h6001, 1'b0, 16'h0);
        repeat (3) step();
        check("sw_read", bus.in_m, 16'h000A);
        cpu(15'h7000, 1'b1, 16'hFFFF); step();
        check("unmapped_write_fwd", bus.in_m, 16'h0000);
        cpu(15'h7000, 1'b0, 16'h0); step();
        check("unmapped_read", bus.in_m, 16'h0000);
        cpu(15'h6002, 1'b0, 16'h0); step();
        check("unmapped_6002", bus.in_m, 16'h0000);

        // 6: CPU stall/execute cadence, address held over both phases
        for (int i = 0; i < 32; i++) begin
            cpu(pool[i % 8], 1'b0, 16'h0);
            vid_addr = (i % 2 == 1) ? 13'd5 : 13'h1FFF;
            SW = 4'(i);
            step();
            cpu(pool[i % 8], (i % 3) != 0, 16'(i * 16'h1357 + 7));
            kbd_code = 16'(16'h0100 + i);
            kbd_strobe = (i % 5 == 0);
            kbd_release = (i % 7 == 3);
            step();
            kbd_strobe = 1'b0; kbd_release = 1'b0;
        end
        cpu(15'd0, 1'b0, 16'h0);
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
